// File: rtl/pipe_sel_reg_if.sv
// Bundle of the selector/register datapath signals. The master side drives
// the select and control inputs. The slave side is the selector register.
interface pipe_sel_reg_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 4
);

  logic [NUM_IN*WIDTH-1:0] in_bus;
  logic [SEL_W-1:0]        sel;
  logic                    in_valid;
  logic                    en;
  logic                    flush;
  logic [WIDTH-1:0]        sel_out;
  logic [WIDTH-1:0]        q;
  logic                    q_valid;
  logic                    sel_err;
  logic [CNT_W-1:0]        stall_cnt;

  modport master (
    output in_bus, sel, in_valid, en, flush,
    input  sel_out, q, q_valid, sel_err, stall_cnt
  );

  modport slave (
    input  in_bus, sel, in_valid, en, flush,
    output sel_out, q, q_valid, sel_err, stall_cnt
  );

endinterface

// File: rtl/pipe_sel_reg.sv
// N-way source selector fused with a pipeline register. It supports stall,
// flush and valid tracking. Illegal select codes are flagged (sticky) rather
// than propagated as X, and consecutive stall cycles are counted.
module pipe_sel_reg #(
  parameter int               WIDTH     = 32,
  parameter int               NUM_IN    = 3,
  parameter int               SEL_W     = 2,
  parameter logic [WIDTH-1:0] CONST_VAL = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 4
) (
  input logic          clk,
  input logic          reset,
  pipe_sel_reg_if.slave bus
);

  // A bad parameter set must stop elaboration. A bad set would otherwise
  // produce a selector that silently cannot reach the constant.
  if ((NUM_IN < 2) || (NUM_IN > 8) || ((2 ** SEL_W) < (NUM_IN + 1))) begin : g_param_check
    $error("pipe_sel_reg: illegal NUM_IN/SEL_W combination");
  end

  localparam logic [SEL_W-1:0] SEL_CONST = SEL_W'(NUM_IN);

  logic [WIDTH-1:0] q_r;
  logic             q_valid_r;
  logic             sel_err_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [WIDTH-1:0] sel_out_c;
  logic             sel_legal;

  assign sel_legal = (bus.sel <= SEL_CONST);

  // Unregistered selection for same-cycle forwarding. Illegal codes fall back to the held q.
  always_comb begin
    sel_out_c = q_r;
    for (int k = 0; k < NUM_IN; k++) begin
      if (bus.sel == SEL_W'(k)) begin
        sel_out_c = bus.in_bus[k*WIDTH +: WIDTH];
      end
    end
    if (bus.sel == SEL_CONST) begin
      sel_out_c = CONST_VAL;
    end
  end

  // Pipeline register. Flush beats load, load beats hold. A stall counts up and saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r         <= RESET_VAL;
      q_valid_r   <= 1'b0;
      sel_err_r   <= 1'b0;
      stall_cnt_r <= '0;
    end else if (bus.flush) begin
      q_r         <= RESET_VAL;
      q_valid_r   <= 1'b0;
      stall_cnt_r <= '0;
    end else if (bus.en) begin
      stall_cnt_r <= '0;
      if (sel_legal) begin
        q_r       <= sel_out_c;
        q_valid_r <= bus.in_valid;
      end else begin
        sel_err_r <= 1'b1;
      end
    end else if (stall_cnt_r != {CNT_W{1'b1}}) begin
      stall_cnt_r <= stall_cnt_r + 1'b1;
    end
  end

  assign bus.sel_out   = sel_out_c;
  assign bus.q         = q_r;
  assign bus.q_valid   = q_valid_r;
  assign bus.sel_err   = sel_err_r;
  assign bus.stall_cnt = stall_cnt_r;

endmodule

// File: doc/pipe_sel_reg.md
Name: pipe_sel_reg

Overview:
- Parametrised N-way source selector fused with a pipeline register. It is the successor to the combinational 32-bit and 5-bit selectors in the pipelined datapath.
- It sits at stage boundaries (ALU operand, write-register address, write-back data). It selects one of NUM_IN packed inputs or a fixed constant, then registers the result.
- The register supports stall (hold), flush (bubble insert) and valid tracking.
- It detects illegal select codes instead of producing X, and it counts consecutive stall cycles for hazard debug.

Parameters:
- WIDTH, 32, data width of each input and of the output
- NUM_IN, 3, number of data inputs (legal range 2..8)
- SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_IN+1
- CONST_VAL, {WIDTH{1'b1}}, constant selected when sel == NUM_IN (e.g. 5'b11111 for $ra)
- RESET_VAL, 0, value loaded into the data register on reset and on flush
- CNT_W, 4, width of the saturating stall counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_bus  in  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH]
- sel  in  SEL_W  source select
- in_valid  in  1  the current selection carries a real instruction
- en  in  1  register load enable; 0 = stall/hold
- flush  in  1  insert bubble on the next edge
- sel_out  out  WIDTH  combinational selected value, unregistered, for same-cycle forwarding
- q  out  WIDTH  registered selected value
- q_valid  out  1  registered valid
- sel_err  out  1  sticky illegal-select flag
- stall_cnt  out  CNT_W  consecutive stall cycles, saturating

Behaviour:
- Reset: clk and reset are the only clock and reset. reset is asynchronous and active-high; asserting it immediately forces q=RESET_VAL, q_valid=0, sel_err=0, stall_cnt=0, regardless of clk.
- Combinational select (sel_out):
  - sel < NUM_IN → input[sel]
  - sel == NUM_IN → CONST_VAL
  - sel > NUM_IN → sel_out equals the current q. It never produces X.
- Register update on each rising clk edge with reset low, priority flush > en > hold:
  - flush=1: q←RESET_VAL, q_valid←0, stall_cnt←0. This applies even if en=0 or sel is illegal.
  - flush=0, en=1, sel legal: q←sel_out, q_valid←in_valid, stall_cnt←0.
  - flush=0, en=1, sel illegal: q and q_valid hold, sel_err←1, stall_cnt←0.
  - flush=0, en=0: q and q_valid hold. stall_cnt←stall_cnt+1, saturating at 2**CNT_W-1 (no wrap).
- sel_err:
  - Set only when an illegal sel is loaded (en=1, flush=0).
  - An illegal sel while en=0 or flush=1 does not set it.
  - Once set, it stays 1 until reset.
- Latency:
  - sel_out follows its inputs with 0 cycles of latency.
  - q and q_valid take 1 cycle.
- Simultaneous flush and en: flush wins, and the output is a bubble.
- Reset mid-stall: stall_cnt clears asynchronously, and counting restarts from 0 after reset deasserts.
- q_valid=0 does not gate q. The data value is registered regardless of in_valid.
- Elaboration-time check: if 2**SEL_W < NUM_IN+1, or NUM_IN is outside 2..8, the design fails to elaborate.

Test Plan:
1. Reset and legal selection, defaults:
   - Stimulus: reset pulse; in_bus = {32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001}; en=1, in_valid=1; sel stepped 0,1,2,3.
   - Response: q equals 0x00000000 during reset. On the edges after each sel value, q becomes 0xAAAA0001, 0xBBBB0002, 0xCCCC0003, then 0xFFFFFFFF. q_valid=1 throughout.
2. Constant select at WIDTH=5, NUM_IN=2, SEL_W=2:
   - sel=2 → q=5'b11111.
   - sel=3 with en=1 → q holds 5'b11111 and sel_err goes to 1. sel_err stays 1 after sel returns to 0 and q loads input 0.
3. Stall:
   - Stimulus: en=0 for 20 cycles with q=0x1234, CNT_W=4.
   - Response: q stays 0x1234. stall_cnt reads 1,2,…,15 and then stays 15. The first cycle with en=1 clears stall_cnt to 0.
4. Flush priority:
   - Stimulus: q=0x55, then flush=1 and en=1 with sel=0 (input 0 = 0x99).
   - Response: on the next edge q=RESET_VAL (0) and q_valid=0. With flush=1 and en=0, the result is the same bubble and stall_cnt=0.
5. Asynchronous reset mid-operation:
   - Stimulus: assert reset between clock edges while q=0xDEAD, q_valid=1, sel_err=1, stall_cnt=7.
   - Response: all four outputs clear before the next clk edge.
6. Illegal select without load:
   - Stimulus: sel=3 (NUM_IN=2) with en=0, then with flush=1.
   - Response: sel_err stays 0 and sel_out equals q in both cases.
